sync_event_tracker: RTL and testbench
=====================================

Name: sync_event_tracker

Overview:
- Consumes the one-cycle sync-detect pulse from the VLAN sync packet detector, in the same 250 MHz user-logic domain.
- Timestamps each accepted pulse against a free-running cycle counter and measures the interval since the previous accepted pulse.
- Buffers {timestamp, interval} records in a FIFO and presents them on an AXI-stream master.
- Tracks sync lock/loss with a timeout state machine.

Parameters:
- TS_WIDTH, 64, width of free-running timestamp counter and m_ts_tdata.
- FIFO_DEPTH, 8, number of buffered records; power of 2, >= 2.
- TIMEOUT_CYCLES, 250000000, cycles without an accepted pulse before declaring loss (1 s at 250 MHz); range 1..2^32-1.
- MIN_GAP_CYCLES, 16, minimum cycles between accepted pulses; closer pulses are ignored.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset, asynchronous, active-low.
- sync_detected_i  input  1  single-cycle sync pulse from the detector.
- m_ts_tvalid  output  1  record available.
- m_ts_tready  input  1  downstream accepts record.
- m_ts_tdata  output  TS_WIDTH  captured timestamp.
- m_ts_tuser  output  32  interval in cycles since the previous accepted pulse.
- locked_o  output  1  state == LOCKED.
- timeout_o  output  1  one-cycle pulse on the LOCKED->LOST transition.
- event_count_o  output  32  accepted pulses; wraps.
- drop_count_o  output  16  records lost to a full FIFO; saturates at 0xFFFF.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, state UNLOCKED, FIFO empty, ts_cnt 0, gap_cnt 0.
- ts_cnt increments every cycle from 0 after reset and wraps at 2^TS_WIDTH.
- gap_cnt counts cycles since the last accepted pulse.
  - Cleared to 1 on the cycle after an accepted pulse.
  - Saturates at 2^32-1.
- Acceptance:
  - A pulse at cycle N is accepted if state is UNLOCKED or LOST, or if gap_cnt >= MIN_GAP_CYCLES.
  - Otherwise it is ignored: no counter, FIFO or state effect.
- Record for an accepted pulse:
  - Timestamp = ts_cnt value at cycle N.
  - Interval = gap_cnt at cycle N when state is ACQUIRE or LOCKED; 0 when UNLOCKED or LOST.
- FIFO write occurs at N+1, so m_ts_tvalid rises at N+1 if the FIFO was empty (first-word fall-through).
- Handshake:
  - Record pops when m_ts_tvalid && m_ts_tready.
  - tdata and tuser are held stable while tvalid && !tready.
- Full FIFO:
  - Write is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped, drop_count_o increments and event_count_o still increments.
- event_count_o increments at N+1 for every accepted pulse.
- State machine:
  - UNLOCKED: accepted pulse -> ACQUIRE.
  - ACQUIRE: accepted pulse -> LOCKED; gap_cnt == TIMEOUT_CYCLES -> UNLOCKED.
  - LOCKED: accepted pulse -> stay; gap_cnt == TIMEOUT_CYCLES -> LOST, with timeout_o high for exactly that cycle.
  - LOST: accepted pulse -> ACQUIRE.
  - If a pulse and the timeout condition occur in the same cycle, the pulse wins.
- locked_o is registered and reflects the state from the cycle after the transition.
- Reset mid-operation:
  - Immediately clears the FIFO, counters and state; in-flight records are lost.
  - m_ts_tvalid drops asynchronously.

Test Plan:
- Parameters for all scenarios: TIMEOUT=100, MIN_GAP=16, DEPTH=4, tready=1.
- Lock sequence: pulses at ts 10 and 50 -> records {10,0} and {50,40}; locked_o=1 from cycle 52; event_count_o=2.
- Debounce: pulses at 50, 55 and 70 -> pulse at 55 ignored; record {70,20}; event_count_o=2.
- Timeout: lock with pulses at 10 and 50, then none -> timeout_o pulses once at cycle 150; locked_o=0 after. Next pulse at 300 -> record {300,0}, state ACQUIRE.
- Backpressure/overflow:
  - Stimulus: tready=0, 6 accepted pulses 20 cycles apart.
  - Response: fifo_level_o=4, drop_count_o=2, event_count_o=6.
  - Release tready: 4 records in order, oldest first.
  - Full-plus-pop: with FIFO full, a pulse coinciding with a pop is stored, not dropped.
- Reset mid-stream: assert aresetn=0 with 3 records queued -> tvalid=0, fifo_level_o=0, counters 0, locked_o=0. After release, ts_cnt restarts at 0.

Source files
------------

// File: rtl/sync_event_tracker.sv
// sync_event_tracker
//   Timestamps accepted sync-detect pulses against a free-running cycle
//   counter and measures the interval since the previous accepted pulse.
//   The {timestamp, interval} records are queued in a small first-word
//   fall-through FIFO and presented on an AXI-stream master. A timeout FSM
//   tracks lock and loss of the sync stream.
//
//   Ports
//     aclk, aresetn     clock / asynchronous active-low reset
//     sync_detected_i   one-cycle sync pulse from the detector
//     m_ts_*            record stream (tdata = timestamp, tuser = interval)
//     locked_o          registered copy of (state == LOCKED)
//     timeout_o         one-cycle pulse on LOCKED -> LOST
//     event_count_o     accepted pulses (wraps)
//     drop_count_o      records lost to a full FIFO (saturates)
//     fifo_level_o      current FIFO occupancy
module sync_event_tracker #(
  parameter int          TS_WIDTH       = 64,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000,
  parameter logic [31:0] MIN_GAP_CYCLES = 32'd16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            sync_detected_i,
  output logic                            m_ts_tvalid,
  input  logic                            m_ts_tready,
  output logic [TS_WIDTH-1:0]             m_ts_tdata,
  output logic [31:0]                     m_ts_tuser,
  output logic                            locked_o,
  output logic                            timeout_o,
  output logic [31:0]                     event_count_o,
  output logic [15:0]                     drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, LOST} state_t;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [31:0]         iv;
  } rec_t;

  state_t              state;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [31:0]         gap_cnt;
  rec_t                mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;

  logic accept, pop, full, push, gap_expired;
  rec_t new_rec;

  // Pulses are debounced only while we believe we are tracking a stream;
  // from UNLOCKED/LOST any pulse starts (re)acquisition.
  assign accept = sync_detected_i &
                  ((state == UNLOCKED) | (state == LOST) | (gap_cnt >= MIN_GAP_CYCLES));
  assign gap_expired = (gap_cnt == TIMEOUT_CYCLES);

  assign pop  = m_ts_tvalid & m_ts_tready;
  assign full = (level == LW'(FIFO_DEPTH));
  // A same-cycle pop frees the slot, so a full FIFO can still take the write.
  assign push = accept & (~full | pop);

  assign new_rec.ts = ts_cnt;
  assign new_rec.iv = ((state == ACQUIRE) | (state == LOCKED)) ? gap_cnt : 32'd0;

  // tvalid derives straight from the async-reset level so it drops with reset.
  assign m_ts_tvalid  = (level != '0);
  assign m_ts_tdata   = mem[rd_ptr].ts;
  assign m_ts_tuser   = mem[rd_ptr].iv;
  assign fifo_level_o = level;

  // Combinational so the pulse lands in the cycle the timeout is detected;
  // a coincident accepted pulse suppresses it.
  assign timeout_o = (state == LOCKED) & gap_expired & ~accept;

  // Counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_cnt        <= '0;
      gap_cnt       <= '0;
      event_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (accept)              gap_cnt <= 32'd1;
      else if (gap_cnt != '1)  gap_cnt <= gap_cnt + 1'b1;
      if (accept) event_count_o <= event_count_o + 1'b1;
      if (accept && !push && drop_count_o != 16'hFFFF)
        drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // Record FIFO (first-word fall-through; storage cleared so outputs read 0)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_rec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Lock FSM; an accepted pulse always takes priority over the timeout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= UNLOCKED;
      locked_o <= 1'b0;
    end else begin
      locked_o <= (state == LOCKED);
      case (state)
        UNLOCKED: if (accept) state <= ACQUIRE;
        ACQUIRE:  if (accept) state <= LOCKED;
                  else if (gap_expired) state <= UNLOCKED;
        LOCKED:   if (!accept && gap_expired) state <= LOST;
        LOST:     if (accept) state <= ACQUIRE;
        default:  state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_event_tracker.sv
// Directed bench for sync_event_tracker (TIMEOUT=100, MIN_GAP=16, DEPTH=4).
// Inputs are driven and outputs sampled on the falling edge. The bench cycle
// number `cyc` equals the DUT timestamp counter value in that cycle.
module tb_sync_event_tracker;

  localparam int TSW   = 64;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           sync_detected_i = 1'b0;
  logic           m_ts_tready = 1'b1;
  logic           m_ts_tvalid;
  logic [TSW-1:0] m_ts_tdata;
  logic [31:0]    m_ts_tuser;
  logic           locked_o, timeout_o;
  logic [31:0]    event_count_o;
  logic [15:0]    drop_count_o;
  logic [LW-1:0]  fifo_level_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  sync_event_tracker #(
    .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(32'd100), .MIN_GAP_CYCLES(32'd16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .sync_detected_i(sync_detected_i),
    .m_ts_tvalid(m_ts_tvalid), .m_ts_tready(m_ts_tready),
    .m_ts_tdata(m_ts_tdata), .m_ts_tuser(m_ts_tuser),
    .locked_o(locked_o), .timeout_o(timeout_o),
    .event_count_o(event_count_o), .drop_count_o(drop_count_o),
    .fifo_level_o(fifo_level_o)
  );

  always #2 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse(input int n);
    goto(n);
    sync_detected_i = 1'b1;
    tick();
    sync_detected_i = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    sync_detected_i = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    cyc = 0;
  endtask

  task automatic chk_rec(input string tag, input logic [63:0] ts, input logic [63:0] iv);
    chk({tag, ".tvalid"}, 64'(m_ts_tvalid), 64'd1);
    chk({tag, ".ts"}, 64'(m_ts_tdata), ts);
    chk({tag, ".iv"}, 64'(m_ts_tuser), iv);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.tvalid", 64'(m_ts_tvalid), 64'd0);
    chk("rst.level",  64'(fifo_level_o), 64'd0);
    chk("rst.locked", 64'(locked_o), 64'd0);
    chk("rst.timeout", 64'(timeout_o), 64'd0);
    chk("rst.events", 64'(event_count_o), 64'd0);
    chk("rst.drops",  64'(drop_count_o), 64'd0);
    chk("rst.tdata",  64'(m_ts_tdata), 64'd0);

    // Lock sequence
    m_ts_tready = 1'b1;
    pulse(10);
    chk_rec("lock.r0", 64'd10, 64'd0);
    chk("lock.ev1", 64'(event_count_o), 64'd1);
    pulse(50);
    chk_rec("lock.r1", 64'd50, 64'd40);
    chk("lock.ev2", 64'(event_count_o), 64'd2);
    chk("lock.locked51", 64'(locked_o), 64'd0);
    tick();
    chk("lock.locked52", 64'(locked_o), 64'd1);

    // Timeout on the same stream
    goto(149);
    chk("to.pre", 64'(timeout_o), 64'd0);
    goto(150);
    chk("to.hit", 64'(timeout_o), 64'd1);
    goto(151);
    chk("to.post", 64'(timeout_o), 64'd0);
    goto(152);
    chk("to.unlocked", 64'(locked_o), 64'd0);
    pulse(300);
    chk_rec("to.reacq", 64'd300, 64'd0);
    pulse(320);   // interval reported only if state was ACQUIRE
    chk_rec("to.acq", 64'd320, 64'd20);
    tick();
    chk("to.relock", 64'(locked_o), 64'd1);

    // Debounce
    do_reset();
    m_ts_tready = 1'b1;
    pulse(50);
    chk_rec("db.r0", 64'd50, 64'd0);
    pulse(55);
    chk("db.ign.tvalid", 64'(m_ts_tvalid), 64'd0);
    chk("db.ign.ev", 64'(event_count_o), 64'd1);
    pulse(70);
    chk_rec("db.r1", 64'd70, 64'd20);
    chk("db.ev", 64'(event_count_o), 64'd2);

    // Backpressure / overflow
    do_reset();
    m_ts_tready = 1'b0;
    for (int i = 0; i < 6; i++) pulse(10 + 20 * i);
    chk("ov.level", 64'(fifo_level_o), 64'd4);
    chk("ov.drops", 64'(drop_count_o), 64'd2);
    chk("ov.events", 64'(event_count_o), 64'd6);
    goto(115);
    chk_rec("ov.hold", 64'd10, 64'd0);
    goto(120);
    m_ts_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("ov.drain%0d", i), 64'(10 + 20 * i), (i == 0) ? 64'd0 : 64'd20);
      tick();
    end
    chk("ov.empty", 64'(m_ts_tvalid), 64'd0);
    chk("ov.level0", 64'(fifo_level_o), 64'd0);

    // Full FIFO with a pulse coinciding with a pop
    do_reset();
    m_ts_tready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(10 + 20 * i);
    goto(90);
    sync_detected_i = 1'b1;
    m_ts_tready = 1'b1;
    tick();
    sync_detected_i = 1'b0;
    m_ts_tready = 1'b0;
    chk("fp.level", 64'(fifo_level_o), 64'd4);
    chk("fp.drops", 64'(drop_count_o), 64'd0);
    chk("fp.events", 64'(event_count_o), 64'd5);
    m_ts_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_rec($sformatf("fp.drain%0d", i), 64'(30 + 20 * i), 64'd20);
      tick();
    end

    // Reset mid-stream
    do_reset();
    m_ts_tready = 1'b0;
    for (int i = 0; i < 3; i++) pulse(10 + 20 * i);
    goto(60);
    chk("mr.level3", 64'(fifo_level_o), 64'd3);
    chk("mr.locked", 64'(locked_o), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mr.tvalid", 64'(m_ts_tvalid), 64'd0);
    chk("mr.level", 64'(fifo_level_o), 64'd0);
    chk("mr.events", 64'(event_count_o), 64'd0);
    chk("mr.locked0", 64'(locked_o), 64'd0);
    chk("mr.tdata", 64'(m_ts_tdata), 64'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    cyc = 0;
    m_ts_tready = 1'b1;
    pulse(5);
    chk_rec("mr.restart", 64'd5, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
